// File: rtl/veopixels_pkg.sv
// Shared types for the Veopixels chase engine: pixel format and animation modes.
// Pixels are GRB-ordered words exactly as they leave on the wire.
package veopixels_pkg;

    localparam int PIXEL_W = 24;

    typedef enum logic [1:0] {
        MODE_HOLD   = 2'b00,
        MODE_UP     = 2'b01,
        MODE_DOWN   = 2'b10,
        MODE_BOUNCE = 2'b11
    } chase_mode_t;

    typedef logic [PIXEL_W-1:0] pixel_t;

endpackage

// File: rtl/veopixels_step_timer.sv
// Free-running step tick generator: one tick every STEP_CYCLES enabled cycles.
// The counter freezes while disabled and restarts from zero on clear.
module veopixels_step_timer #(
    parameter int STEP_CYCLES = 5_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = $clog2(STEP_CYCLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STEP_CYCLES - 1);

    logic [CNT_W-1:0] r_count;

    assign tick = enable && (r_count == LAST);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_count <= '0;
        end else if (enable) begin
            if (r_count == LAST) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/veopixels_chase_engine.sv
// Frame-buffer animator feeding the Veopixels encoder: rotates or bounces the strip
// on each timer tick, but only applies a step while the encoder is between frames.
module veopixels_chase_engine #(
    parameter int LENGTH      = 16,
    parameter int PIXEL_W     = 24,
    parameter int STEP_CYCLES = 5_000_000,
    parameter int POS_W       = $clog2(LENGTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic [1:0]                mode,
    input  logic                      load,
    input  logic [LENGTH*PIXEL_W-1:0] load_strip,
    input  logic                      frame_ready,
    output logic [LENGTH*PIXEL_W-1:0] strip,
    output logic [POS_W-1:0]          pos,
    output logic                      dir,
    output logic                      step_pulse
);

    import veopixels_pkg::*;

    localparam logic [POS_W-1:0] POS_LAST = POS_W'(LENGTH - 1);

    chase_mode_t               w_mode;
    logic                      w_tick;
    logic                      w_apply;
    logic                      w_goUp;
    logic [POS_W-1:0]          w_posInc;
    logic [POS_W-1:0]          w_posDec;
    logic [POS_W-1:0]          w_nextPos;
    logic [LENGTH*PIXEL_W-1:0] w_rotUp;
    logic [LENGTH*PIXEL_W-1:0] w_rotDown;

    logic [LENGTH*PIXEL_W-1:0] r_strip;
    logic [POS_W-1:0]          r_pos;
    logic                      r_dir;
    logic                      r_stepPulse;
    logic                      r_pending;

    veopixels_step_timer #(
        .STEP_CYCLES(STEP_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .clear  (load),
        .tick   (w_tick)
    );

    // Both rotation candidates are pure wiring; the mode only picks one at apply time.
    for (genvar i = 0; i < LENGTH; i++) begin : g_pix
        localparam int UP_SRC   = (i + LENGTH - 1) % LENGTH;
        localparam int DOWN_SRC = (i + 1) % LENGTH;
        assign w_rotUp[i*PIXEL_W +: PIXEL_W]   = r_strip[UP_SRC*PIXEL_W +: PIXEL_W];
        assign w_rotDown[i*PIXEL_W +: PIXEL_W] = r_strip[DOWN_SRC*PIXEL_W +: PIXEL_W];
    end

    assign w_mode    = chase_mode_t'(mode);
    assign w_goUp    = (w_mode == MODE_UP) || ((w_mode == MODE_BOUNCE) && !r_dir);
    assign w_apply   = r_pending && frame_ready && (w_mode != MODE_HOLD);
    assign w_posInc  = (r_pos == POS_LAST) ? '0 : r_pos + 1'b1;
    assign w_posDec  = (r_pos == '0) ? POS_LAST : r_pos - 1'b1;
    assign w_nextPos = w_goUp ? w_posInc : w_posDec;

    // A tick that lands while a step is already waiting is simply absorbed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= 1'b0;
        end else if (load || (w_mode == MODE_HOLD)) begin
            r_pending <= 1'b0;
        end else if (w_tick) begin
            r_pending <= 1'b1;
        end else if (w_apply) begin
            r_pending <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_strip     <= '0;
            r_pos       <= '0;
            r_dir       <= 1'b0;
            r_stepPulse <= 1'b0;
        end else if (load) begin
            r_strip     <= load_strip;
            r_pos       <= '0;
            r_dir       <= 1'b0;
            r_stepPulse <= 1'b0;
        end else begin
            r_stepPulse <= w_apply;
            if (w_apply) begin
                r_strip <= w_goUp ? w_rotUp : w_rotDown;
                r_pos   <= w_nextPos;
                if (w_mode == MODE_BOUNCE) begin
                    if (w_nextPos == POS_LAST) begin
                        r_dir <= 1'b1;
                    end else if (w_nextPos == '0) begin
                        r_dir <= 1'b0;
                    end
                end
            end
        end
    end

    assign strip      = r_strip;
    assign pos        = r_pos;
    assign dir        = r_dir;
    assign step_pulse = r_stepPulse;

endmodule
